alu_operand_stage: RTL and testbench

- Pipeline register stage that captures ALU operand pairs from decode and presents them to the operand-B inverter and adder datapath.
- A 2-entry skid buffer with valid/ready handshakes on both sides gives full throughput with registered ready.
- Downstream uses out_b directly, or through the 8-bit inverter when out_sub=1, with carry-in = out_sub.
- Keeps an 8-bit count of delivered operations for debug.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/skid_buffer2.sv | 73 +++++++
 rtl/alu_operand_stage.sv | 55 +++++
 tb/tb_alu_operand_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU operand stage
package alu_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_t;

    // Bundle layout as carried through the buffer: {sub, b, a}.
    typedef struct packed {
        logic              sub;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] a;
    } operand_t;

    localparam int BUNDLE_W = $bits(operand_t);

endpackage

// File: rtl/skid_buffer2.sv
// rtl/skid_buffer2.sv - generic 2-entry valid/ready skid buffer with registered ready
import alu_pkg::*;

module skid_buffer2 #(
    parameter int DW = BUNDLE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    buf_state_t    state_q, state_d;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid_i && in_ready_q;
    assign out_fire = out_valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (in_fire)               state_d = ST_ONE;
            ST_ONE:   if (in_fire && !out_fire)  state_d = ST_FULL;
                      else if (!in_fire && out_fire) state_d = ST_EMPTY;
            ST_FULL:  if (out_fire)              state_d = ST_ONE;
            default:                             state_d = ST_EMPTY;
        endcase
    end

    // Ready and valid are registered straight from the next state so neither
    // side sees a combinational path through this stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            unique case (state_q)
                ST_EMPTY: if (in_fire) head_q <= in_data_i;
                ST_ONE: begin
                    if (in_fire && out_fire)  head_q <= in_data_i;
                    else if (in_fire)         skid_q <= in_data_i;
                end
                ST_FULL:  if (out_fire) head_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = head_q;

    a_in_valid_held: assert property (
        @(posedge clk) disable iff (!rst_n)
        (in_valid_i && !in_ready_o) |=> in_valid_i
    ) else $error("in_valid dropped before it was accepted");

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand pipeline stage between decode and the inverter/adder
import alu_pkg::*;

module alu_operand_stage #(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_sub,
    output logic [CNT_W-1:0] op_count
);

    localparam int BW = 2 * WIDTH + 1;

    logic [BW-1:0]    in_bundle;
    logic [BW-1:0]    out_bundle;
    logic [CNT_W-1:0] op_count_q;

    assign in_bundle = {in_sub, in_b, in_a};

    skid_buffer2 #(
        .DW (BW)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_bundle),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_bundle)
    );

    assign {out_sub, out_b, out_a} = out_bundle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count_q <= '0;
        else if (out_valid && out_ready)
            op_count_q <= op_count_q + CNT_W'(1);
    end

    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_sub;
    logic [7:0] op_count;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;

    alu_operand_stage #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_sub   (out_sub),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one op and return at posedge+1 after it was accepted; in_valid stays high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, output int stalls);
        logic acc;
        stalls   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        exp_q.push_back({s, b, a});
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            stalls++;
            if (stalls > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: op %h/%h never accepted", a, b);
                break;
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        in_sub   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer pops the scoreboard and checks the counter model.
    initial begin : monitor
        logic [16:0] got;
        logic [16:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 8'd0;
            end else if (out_valid && out_ready) begin
                got = {out_sub, out_b, out_a};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard at %0t", got, $time);
                end else begin
                    exp = exp_q.pop_front();
                    chk("fifo_data", got, exp);
                end
                chk("op_count_model", op_count, exp_cnt);
                exp_cnt = exp_cnt + 8'd1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int st;
        int max_st;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {out_sub, out_b, out_a}, 0);
        chk("rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Single subtract op
        out_ready = 1'b1;
        send(8'h3C, 8'h0F, 1'b1, st);
        idle();
        chk("single_valid", out_valid, 1);
        chk("single_data", {out_sub, out_b, out_a}, {1'b1, 8'h0F, 8'h3C});
        @(posedge clk);
        #1;
        chk("single_gone", out_valid, 0);
        chk("single_count", op_count, 1);

        // Back-pressure: two fill the buffer, the third waits
        out_ready = 1'b0;
        fork
            begin
                send(8'h11, 8'h22, 1'b0, st);
                send(8'h33, 8'h44, 1'b0, st);
                send(8'h55, 8'h66, 1'b0, st);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("bp_in_ready_low", in_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                chk("bp_head_stable", {out_sub, out_b, out_a}, {1'b0, 8'h22, 8'h11});
                chk("bp_still_full", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_in_ready_back", in_ready, 1);

        // Full throughput with counter wrap
        do_reset();
        out_ready = 1'b1;
        max_st    = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 8'(255 - i), i[0], st);
            if (st > max_st) max_st = st;
        end
        idle();
        drain("tput_drain");
        chk("tput_no_stalls", max_st, 0);
        chk("tput_count_wrap", op_count, 0);

        // Simultaneous in/out while ONE
        out_ready = 1'b0;
        send(8'hAA, 8'h01, 1'b0, st);
        idle();
        @(posedge clk);
        #1;
        chk("sim_head_aa", out_a, 8'hAA);
        out_ready = 1'b1;
        send(8'hBB, 8'h02, 1'b1, st);
        idle();
        chk("sim_no_stall", st, 0);
        chk("sim_head_bb", {out_sub, out_b, out_a}, {1'b1, 8'h02, 8'hBB});
        chk("sim_one_valid", out_valid, 1);
        chk("sim_one_ready", in_ready, 1);
        drain("sim_drain");
        chk("sim_count", op_count, 2);

        // Reset while FULL
        out_ready = 1'b0;
        send(8'hC1, 8'hD1, 1'b0, st);
        send(8'hC2, 8'hD2, 1'b1, st);
        idle();
        chk("mid_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_out_valid_async", out_valid, 0);
        chk("mid_in_ready_async", in_ready, 0);
        chk("mid_outputs_async", {out_sub, out_b, out_a}, 0);
        chk("mid_count_async", op_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_no_stale", out_valid, 0);
        chk("mid_ready_after", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
